// File: rtl/wb_stage_pkg.sv
// Shared constants and debug-tag types for the MIPS write-back stage.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_CNT_W  = 32;
    localparam int unsigned TAG_W     = 4;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Debug instruction-type encodings carried alongside each instruction
    typedef enum logic [TAG_W-1:0] {
        INS_NOP    = 4'd0,
        INS_ALU    = 4'd1,
        INS_LOAD   = 4'd2,
        INS_STORE  = 4'd3,
        INS_BRANCH = 4'd4,
        INS_JUMP   = 4'd5
    } ins_type_e;

    typedef struct packed {
        logic [TAG_W-1:0] ins_type;
        logic [TAG_W-1:0] ins_number;
    } dbg_tag_t;

endpackage

// File: rtl/wb_retire_cnt.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, async active-low clear.
module wb_retire_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: WB pipeline register, write-data select, regfile write
// port, one-deep write history for late-hazard bypass and retired counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [ADDR_W-1:0] mem_destR,
    input  logic [DATA_W-1:0] mem_aluR,
    input  logic [DATA_W-1:0] mem_mdata,
    input  logic [3:0]        MEM_ins_type,
    input  logic [3:0]        MEM_ins_number,
    output logic [ADDR_W-1:0] wb_destR,
    output logic [DATA_W-1:0] wb_dest,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] last_destR,
    output logic [DATA_W-1:0] last_dest,
    output logic              last_wreg,
    output logic [CNT_W-1:0]  retired,
    output logic [3:0]        WB_ins_type,
    output logic [3:0]        WB_ins_number
);

    logic              v_q, v_d;
    logic              wreg_q, wreg_d;
    logic              m2reg_q, m2reg_d;
    logic [ADDR_W-1:0] destR_q, destR_d;
    logic [DATA_W-1:0] aluR_q, aluR_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    dbg_tag_t          tag_q, tag_d;

    logic [ADDR_W-1:0] last_destR_q;
    logic [DATA_W-1:0] last_dest_q;
    logic              last_wreg_q;

    logic              load_c;

    assign load_c = !flush && !stall;

    // Next-state for the WB register: flush > stall > load
    always_comb begin
        v_d     = v_q;
        wreg_d  = wreg_q;
        m2reg_d = m2reg_q;
        destR_d = destR_q;
        aluR_d  = aluR_q;
        mdata_d = mdata_q;
        tag_d   = tag_q;
        if (flush) begin
            v_d     = 1'b0;
            wreg_d  = 1'b0;
            m2reg_d = 1'b0;
            destR_d = '0;
            aluR_d  = '0;
            mdata_d = '0;
            tag_d   = '0;
        end else if (!stall) begin
            v_d     = mem_valid;
            wreg_d  = mem_wreg & mem_valid;
            m2reg_d = mem_m2reg;
            destR_d = mem_destR;
            aluR_d  = mem_aluR;
            mdata_d = mem_mdata;
            tag_d   = '{ins_type: MEM_ins_type, ins_number: MEM_ins_number};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q          <= 1'b0;
            wreg_q       <= 1'b0;
            m2reg_q      <= 1'b0;
            destR_q      <= '0;
            aluR_q       <= '0;
            mdata_q      <= '0;
            tag_q        <= '0;
            last_destR_q <= '0;
            last_dest_q  <= '0;
            last_wreg_q  <= 1'b0;
        end else begin
            v_q          <= v_d;
            wreg_q       <= wreg_d;
            m2reg_q      <= m2reg_d;
            destR_q      <= destR_d;
            aluR_q       <= aluR_d;
            mdata_q      <= mdata_d;
            tag_q        <= tag_d;
            last_destR_q <= wb_destR;
            last_dest_q  <= wb_dest;
            last_wreg_q  <= wb_wreg;
        end
    end

    // A held instruction must not write again, and $zero is never written
    assign wb_dest       = m2reg_q ? mdata_q : aluR_q;
    assign wb_destR      = destR_q;
    assign wb_wreg       = v_q & wreg_q & (destR_q != ADDR_W'(REG_ZERO)) & !stall;
    assign WB_ins_type   = tag_q.ins_type;
    assign WB_ins_number = tag_q.ins_number;

    assign last_destR = last_destR_q;
    assign last_dest  = last_dest_q;
    assign last_wreg  = last_wreg_q;

    wb_retire_cnt #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (load_c & mem_valid),
        .cnt_o (retired)
    );

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline.
- Registers MEM-stage results and selects the ALU result or the load data.
- Drives the register-file write port (wb_destR / wb_dest / wb_wreg) consumed by the decode stage.
- Also provides a one-deep write history for late-hazard bypass, a retired-instruction counter, and debug instruction tags.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold WB pipeline register.
- flush  in  1  insert bubble into WB.
- mem_valid  in  1  MEM slot holds a real instruction.
- mem_wreg  in  1  instruction writes a register.
- mem_m2reg  in  1  1: write load data; 0: write ALU result.
- mem_destR  in  ADDR_W  destination register (rt/rd already selected).
- mem_aluR  in  DATA_W  ALU result.
- mem_mdata  in  DATA_W  data-memory read data.
- MEM_ins_type  in  4  debug tag.
- MEM_ins_number  in  4  debug tag.
- wb_destR  out  ADDR_W  regfile write address.
- wb_dest  out  DATA_W  regfile write data.
- wb_wreg  out  1  regfile write enable.
- last_destR  out  ADDR_W  previous cycle's write address.
- last_dest  out  DATA_W  previous cycle's write data.
- last_wreg  out  1  previous cycle's write enable.
- retired  out  CNT_W  count of valid instructions entering WB.
- WB_ins_type  out  4  debug tag.
- WB_ins_number  out  4  debug tag.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and internal registers clear to 0 immediately. Reset asserted mid-operation discards the in-flight instruction and clears retired.
- Internal register set: v, wreg, m2reg, destR, aluR, mdata, type, number.
- Update priority on each rising clk (rst=1): flush > stall > load.
  - flush=1: v, wreg, destR and both debug tags clear to 0; data registers are don't-care and are cleared to 0.
  - stall=1 (flush=0): all WB registers hold.
  - otherwise: all WB registers load from the MEM inputs; wreg loads mem_wreg & mem_valid.
- Outputs (combinational from the WB registers, 0 added cycles):
  - wb_dest = m2reg ? mdata : aluR.
  - wb_destR = destR.
  - wb_wreg = v & wreg & (destR != 0); $zero is never written.
  - wb_wreg is forced to 0 while stall=1 so a held instruction writes only once. The write happens in the cycle it first appears, before any stall.
- Latency: MEM inputs at edge N appear on wb_* during cycle N..N+1; the regfile commits at edge N+1.
- History registers: on each rising clk, last_destR/last_dest/last_wreg load the current wb_destR/wb_dest/wb_wreg, independent of stall and flush. They cover the regfile read-after-write window (no write-through in the regfile).
- retired: increments by 1 at an edge where the load path is taken and mem_valid=1. It does not increment on stall, flush or bubble. It wraps modulo 2^CNT_W (all-ones +1 -> 0). Stores and branches are counted; write enable is irrelevant.
- Simultaneous flush+stall: flush wins; the bubble is inserted.
- mem_valid=0 with mem_wreg=1: no write; retired does not change.

Decomposition:
- Shared package/macro header (macro.vh): DATA_W, ADDR_W, REG_ZERO=5'd0, debug ins_type encodings.
- One natural sub-module: wb_retire_cnt (CNT_W counter with enable and async active-low clear).
- Write-data mux, pipeline register and history register stay inline.

Test Plan:
- ALU write: mem_valid=1, wreg=1, m2reg=0, destR=8, aluR=0x0000_1234, edge -> wb_wreg=1, wb_destR=8, wb_dest=0x1234, retired=1; next edge -> last_dest=0x1234, last_wreg=1.
- Load write: m2reg=1, mdata=0xDEAD_BEEF, aluR=0x10, destR=9 -> wb_dest=0xDEADBEEF; regfile read of $9 via which_reg returns 0xDEADBEEF after the following edge.
- $zero suppression: wreg=1, destR=0, aluR=5 -> wb_wreg=0; retired still increments by 1.
- Stall/flush priority: load destR=3 and value 7, then stall=1 for 3 cycles -> wb_wreg=0 and retired unchanged during the stall. Then flush=1 together with stall=1 -> next cycle v=0, destR=0, WB_ins_type=0.
- Wrap: force retired to 0xFFFF_FFFF, one valid load edge -> retired=0.
- Async reset mid-stream: pull rst low between edges with wb_wreg=1 -> all outputs are 0 before the next edge. Release rst; the first valid instruction yields retired=1.
